// File: rtl/apb_master_arbiter_if.sv
// Bundle of the four-requester front end and the APB master/slave signals
// used by apb_master_arbiter.
interface apb_master_arbiter_if;
    // Handshake: a requester raises req[r] with addr/write/wdata stable and holds
    // it until ack[r] pulses for one cycle; ack_rdata/ack_err are meaningful only
    // in that cycle. APB side: the transfer completes in the ACCESS cycle
    // (psel & penable) whose pready is 1.
    logic [3:0]   req;
    logic [127:0] req_addr;
    logic [3:0]   req_write;
    logic [127:0] req_wdata;
    logic [3:0]   ack;
    logic [31:0]  ack_rdata;
    logic         ack_err;
    logic         busy;
    logic [1:0]   state_dbg;
    logic [31:0]  paddr;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic         penable;
    logic [15:0]  psel;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;

    modport master (
        input  req, req_addr, req_write, req_wdata, prdata, pready, pslverr,
        output ack, ack_rdata, ack_err, busy, state_dbg,
               paddr, pwrite, pwdata, penable, psel
    );

    modport slave (
        output req, req_addr, req_write, req_wdata, prdata, pready, pslverr,
        input  ack, ack_rdata, ack_err, busy, state_dbg,
               paddr, pwrite, pwdata, penable, psel
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter for four requesters in front of a single APB master,
// with an optional PREADY timeout that aborts stalled transfers with an error.
module apb_master_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic pclk,
    input logic preset,
    apb_master_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t      state;
    logic [1:0]  grant;
    logic [1:0]  last_grant;
    logic [7:0]  wait_cnt;
    logic [3:0]  ack_q;
    logic [31:0] ack_rdata_q;
    logic        ack_err_q;
    logic [31:0] paddr_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic        penable_q;
    logic [15:0] psel_q;

    logic [3:0]  eligible;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        pick_valid;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_write;
    logic        timeout_hit;

    // Scan from last_grant+4 down to last_grant+1 so the nearest successor wins.
    always_comb begin
        eligible   = bus.req & ~ack_q;
        pick       = last_grant;
        pick_valid = 1'b0;
        idx        = last_grant;
        for (int i = 4; i >= 1; i--) begin
            idx = last_grant + 2'(i);
            if (eligible[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
        sel_addr    = bus.req_addr[{pick, 5'd0} +: 32];
        sel_wdata   = bus.req_wdata[{pick, 5'd0} +: 32];
        sel_write   = bus.req_write[pick];
        timeout_hit = (TIMEOUT != 0) && !bus.pready && (wait_cnt == TO_LAST);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            grant       <= 2'd3;
            last_grant  <= 2'd3;
            wait_cnt    <= '0;
            ack_q       <= '0;
            ack_rdata_q <= '0;
            ack_err_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            penable_q   <= 1'b0;
            psel_q      <= '0;
        end else begin
            ack_q       <= '0;
            ack_rdata_q <= '0;
            ack_err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= SETUP;
                        grant      <= pick;
                        last_grant <= pick;
                        paddr_q    <= sel_addr;
                        pwrite_q   <= sel_write;
                        pwdata_q   <= sel_wdata;
                        psel_q     <= 16'd1 << sel_addr[27:24];
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                end
                ACCESS: begin
                    // A timeout completes like a normal transfer but reports an error.
                    if (bus.pready || timeout_hit) begin
                        state       <= IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        ack_q       <= 4'd1 << grant;
                        ack_err_q   <= bus.pready ? bus.pslverr : 1'b1;
                        ack_rdata_q <= (bus.pready && !pwrite_q) ? bus.prdata : '0;
                    end else if (wait_cnt != 8'hff) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.ack_rdata = ack_rdata_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.penable   = penable_q;
    assign bus.psel      = psel_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus randomized traffic,
// scored against a transaction-level timing model of the arbiter.
module tb_apb_master_arbiter;
    localparam int TO_MAIN = 16;
    localparam int TO_SHORT = 4;

    logic pclk;
    logic preset;
    apb_master_arbiter_if bus ();
    apb_master_arbiter_if bus4 ();

    apb_master_arbiter #(.TIMEOUT(TO_MAIN)) dut (
        .pclk(pclk), .preset(preset), .bus(bus.master)
    );
    apb_master_arbiter #(.TIMEOUT(TO_SHORT)) dut_t4 (
        .pclk(pclk), .preset(preset), .bus(bus4.master)
    );

    // ---------------- clock / reset ----------------
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;
    bit rand_mode = 1'b0;
    logic [3:0] hold_mask = 4'h0;

    // exp_q entry: {ack cycle[31:0], ack mask[3:0], rdata[31:0], err}
    logic [68:0] exp_q[$];
    // slave_q / dir_q entry: {wait states[7:0], prdata[31:0], pslverr}
    logic [40:0] slave_q[$];
    logic [40:0] dir_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge pclk);
        preset = 1'b1;
        repeat (n) @(negedge pclk);
        preset = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int r, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        bus.req_addr[32*r +: 32]  = addr;
        bus.req_wdata[32*r +: 32] = wd;
        bus.req_write[r]          = wr;
        bus.req[r]                = 1'b1;
    endtask

    task automatic new_rand_req(input int r);
        set_req(r, $urandom, 1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((bus.req != 4'h0 || exp_q.size() != 0) && t < 400) begin
            @(negedge pclk);
            t++;
        end
        chk(name, 64'(t < 400), 64'd1);
    endtask

    // Requesters hold req until their ack, then drop or (randomly) reissue.
    always @(negedge pclk) begin
        if (!preset) begin
            for (int r = 0; r < 4; r++) begin
                if (bus.ack[r] === 1'b1) begin
                    if (rand_mode && $urandom_range(0, 1) == 1) new_rand_req(r);
                    else if (!hold_mask[r]) bus.req[r] = 1'b0;
                end else if (rand_mode && !bus.req[r] && $urandom_range(0, 2) == 0) begin
                    new_rand_req(r);
                end
            end
        end
    end

    // APB slave: response parameters come from the model at grant time.
    logic [7:0]  s_nw;
    logic [31:0] s_rdata;
    logic        s_err;
    int          s_k = 0;
    always @(negedge pclk) begin
        if (bus.psel != 16'h0 && bus.penable == 1'b0) begin
            if (slave_q.size() == 0) chk("slave_setup_without_grant", 64'(slave_q.size()), 64'd1);
            else begin
                {s_nw, s_rdata, s_err} = slave_q.pop_front();
                s_k = 0;
            end
        end
        if (bus.penable === 1'b1) begin
            bus.pready  = (s_k == int'(s_nw));
            bus.prdata  = bus.pready ? s_rdata : $urandom;
            bus.pslverr = bus.pready ? s_err : 1'($urandom_range(0, 1));
            s_k++;
        end else begin
            bus.pready  = 1'($urandom_range(0, 1));
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- reference model ----------------
    int m_last, m_setup, m_ack, m_free, m_g, m_nw, m_acc;
    logic [3:0]  m_ack_mask, m_elig;
    logic [31:0] cur_addr, cur_wdata, m_rdata, e_rdata;
    logic        cur_write, m_err, e_err, m_found, m_timed;
    logic [40:0] m_rsp;

    always @(posedge pclk) begin
        cyc++;
        if (preset) begin
            m_last = 3; m_setup = -10; m_ack = -10; m_free = 0; m_ack_mask = 4'h0;
            cur_addr = '0; cur_wdata = '0; cur_write = 1'b0;
            exp_q.delete();
            slave_q.delete();
        end else if (cyc >= m_free) begin
            m_elig  = bus.req & ((cyc - 1 == m_ack) ? ~m_ack_mask : 4'hf);
            m_found = 1'b0;
            m_g     = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!m_found && m_elig[(m_last + k) % 4]) begin
                    m_g = (m_last + k) % 4;
                    m_found = 1'b1;
                end
            end
            if (m_found) begin
                if (dir_q.size() != 0) m_rsp = dir_q.pop_front();
                else m_rsp = {8'(($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(14, 18)),
                              32'($urandom), 1'($urandom_range(0, 1))};
                m_nw    = int'(m_rsp[40:33]);
                m_rdata = m_rsp[32:1];
                m_err   = m_rsp[0];
                m_timed = (TO_MAIN != 0) && (m_nw >= TO_MAIN);
                m_acc   = m_timed ? TO_MAIN : m_nw + 1;
                cur_addr  = bus.req_addr[32*m_g +: 32];
                cur_wdata = bus.req_wdata[32*m_g +: 32];
                cur_write = bus.req_write[m_g];
                m_last  = m_g;
                m_setup = cyc;
                m_ack   = cyc + m_acc + 1;
                m_free  = m_ack + 1;
                m_ack_mask = 4'b0001 << m_g;
                e_rdata = (m_timed || cur_write) ? 32'h0 : m_rdata;
                e_err   = m_timed ? 1'b1 : m_err;
                exp_q.push_back({32'(m_ack), m_ack_mask, e_rdata, e_err});
                slave_q.push_back(m_rsp);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [68:0] e;
    logic        e_busy, e_pen;
    logic [15:0] e_psel;
    always @(negedge pclk) begin
        if (mon_en && !preset) begin
            e_busy = (cyc >= m_setup) && (cyc < m_ack);
            e_pen  = (cyc > m_setup) && (cyc < m_ack);
            e_psel = e_busy ? (16'd1 << cur_addr[27:24]) : 16'h0;
            chk("busy", 64'(bus.busy), 64'(e_busy));
            chk("penable", 64'(bus.penable), 64'(e_pen));
            chk("psel", 64'(bus.psel), 64'(e_psel));
            chk("paddr", 64'(bus.paddr), 64'(cur_addr));
            chk("pwrite", 64'(bus.pwrite), 64'(cur_write));
            chk("pwdata", 64'(bus.pwdata), 64'(cur_wdata));
            if (bus.ack !== 4'h0 || (exp_q.size() != 0 && int'(exp_q[0][68:37]) == cyc)) begin
                if (exp_q.size() == 0) chk("ack_unexpected", 64'(bus.ack), 64'h0);
                else begin
                    e = exp_q.pop_front();
                    chk("ack_cycle", 64'(cyc), 64'(e[68:37]));
                    chk("ack_mask", 64'(bus.ack), 64'(e[36:33]));
                    chk("ack_rdata", 64'(bus.ack_rdata), 64'(e[32:1]));
                    chk("ack_err", 64'(bus.ack_err), 64'(e[0]));
                end
            end else begin
                chk("idle_ack_rdata", 64'(bus.ack_rdata), 64'h0);
                chk("idle_ack_err", 64'(bus.ack_err), 64'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    int t;
    int n_acc;
    bit got;
    initial begin
        preset = 1'b1;
        bus.req = '0; bus.req_addr = '0; bus.req_write = '0; bus.req_wdata = '0;
        bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        bus4.req = '0; bus4.req_addr = '0; bus4.req_write = '0; bus4.req_wdata = '0;
        bus4.prdata = 32'h1234_5678; bus4.pready = 1'b0; bus4.pslverr = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        mon_en = 1'b1;
        @(negedge pclk);

        // Single read from requester 0, zero wait states.
        dir_q.push_back({8'd0, 32'hA5A5_0001, 1'b0});
        set_req(0, 32'h0300_0010, 1'b0, 32'h0);
        wait_idle("single_read_done");

        // Contention right after reset: all four held, zero wait states.
        do_reset(1);
        dir_q.delete();
        for (int i = 0; i < 12; i++) dir_q.push_back({8'd0, 32'h0, 1'b0});
        hold_mask = 4'hf;
        for (int r = 0; r < 4; r++) set_req(r, 32'h0100_0000 * (r + 4) + 32'(r), r[0], 32'hC0DE_0000 + 32'(r));
        repeat (16) @(negedge pclk);
        hold_mask = 4'h0;
        wait_idle("contention_done");
        dir_q.delete();

        // Write with five wait states finishing with a slave error.
        dir_q.push_back({8'd5, 32'hDEAD_BEEF, 1'b1});
        set_req(1, 32'h0F00_0004, 1'b1, 32'h5555_AAAA);
        wait_idle("wait_err_done");
        dir_q.delete();

        // Reset in the middle of ACCESS, then requester 2 alone.
        dir_q.push_back({8'd12, 32'h0, 1'b0});
        set_req(0, 32'h0600_0020, 1'b0, 32'h0);
        t = 0;
        while (bus.penable !== 1'b1 && t < 20) begin
            @(negedge pclk);
            t++;
        end
        chk("reach_access", 64'(t < 20), 64'd1);
        repeat (2) @(negedge pclk);
        preset = 1'b1;
        bus.req = 4'b0000;
        set_req(2, 32'h0A00_0040, 1'b0, 32'h0);
        @(negedge pclk);
        preset = 1'b0;
        dir_q.delete();
        dir_q.push_back({8'd0, 32'h0BAD_F00D, 1'b0});
        wait_idle("post_reset_done");
        dir_q.delete();

        // Randomized traffic, then drain.
        rand_mode = 1'b1;
        repeat (1500) @(negedge pclk);
        rand_mode = 1'b0;
        wait_idle("random_drain");

        // Timeout on the TIMEOUT=4 instance with PREADY held low.
        bus4.req_addr[31:0] = 32'h0200_0000;
        bus4.req = 4'b0001;
        n_acc = 0;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge pclk);
            if (bus4.ack !== 4'h0) begin
                got = 1'b1;
                bus4.req = 4'b0000;
                chk("t4_access_cycles", 64'(n_acc), 64'(TO_SHORT));
                chk("t4_ack", 64'(bus4.ack), 64'h1);
                chk("t4_ack_err", 64'(bus4.ack_err), 64'h1);
                chk("t4_ack_rdata", 64'(bus4.ack_rdata), 64'h0);
                chk("t4_busy", 64'(bus4.busy), 64'h0);
                chk("t4_psel", 64'(bus4.psel), 64'h0);
            end else if (bus4.penable === 1'b1) begin
                n_acc++;
            end
        end
        chk("t4_ack_seen", 64'(got), 64'd1);

        repeat (3) @(negedge pclk);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning the number of ACCESS cycles with PREADY=0 before a transfer is aborted; 0 disables the timeout (0 to 255 legal).
REQ-002 PCLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 PRESET  in  1  synchronous, active-high reset.
REQ-004 REQ  in  4  per-requester transfer request, one bit per requester r=0..3.
REQ-005 REQ_ADDR  in  128  address, bits [32r+31:32r] for requester r.
REQ-006 REQ_WRITE  in  4  1=write, 0=read, bit r.
REQ-007 REQ_WDATA  in  128  write data, bits [32r+31:32r].
REQ-008 ACK  out  4  one-cycle completion pulse, bit r.
REQ-009 ACK_RDATA  out  32  read data, valid while any ACK bit is high.
REQ-010 ACK_ERR  out  1  error status, valid while any ACK bit is high.
REQ-011 BUSY  out  1  high when the FSM is not IDLE.
REQ-012 PADDR  out  32; PWRITE  out  1; PWDATA  out  32; PENABLE  out  1; PSEL  out  16  APB master outputs.
REQ-013 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB slave responses.

Function
REQ-014 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-015 In IDLE with any eligible REQ bit set, the arbiter SHALL grant one requester round-robin, latch its ADDR/WRITE/WDATA into PADDR/PWRITE/PWDATA and enter SETUP on the next edge.
REQ-016 Round-robin order SHALL search from (last granted + 1) mod 4; after reset the last granted index is 3, so requester 0 has highest priority.
REQ-017 In the cycle where ACK[r]=1, REQ[r] SHALL be ineligible; a held REQ[r] is treated as a new request from the following cycle.
REQ-018 Requesters SHALL hold ADDR/WRITE/WDATA stable while REQ is high and ACK is low; the arbiter samples them only at grant.
REQ-019 SETUP SHALL last exactly one cycle with PENABLE=0, then move to ACCESS with PENABLE=1.
REQ-020 PSEL SHALL be one-hot at index PADDR[27:24] in SETUP and ACCESS, and all-zero in IDLE.
REQ-021 In ACCESS with PREADY=1, the next edge SHALL:
- go to IDLE;
- assert ACK[g] for one cycle, g being the granted requester;
- set ACK_RDATA=PRDATA when PWRITE=0, otherwise 0;
- set ACK_ERR=PSLVERR.
REQ-022 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-023 When TIMEOUT>0, PREADY=0 and the counter equals TIMEOUT-1, the next edge SHALL go to IDLE with ACK[g]=1, ACK_ERR=1 and ACK_RDATA=0.
REQ-024 PADDR, PWRITE and PWDATA SHALL hold their last values in IDLE.
REQ-025 PENABLE SHALL be 0 in IDLE and SETUP.
REQ-026 ACK, ACK_RDATA and ACK_ERR SHALL be 0 in every cycle without completion.
REQ-027 Minimum transfer latency SHALL be 3 cycles from REQ sampled high in IDLE to ACK high, with zero wait states.
REQ-028 Back-to-back throughput SHALL be one transfer per 3 cycles with zero wait states; no idle cycle is inserted beyond the ACK/IDLE cycle.
REQ-029 PSLVERR SHALL be ignored except in the completing ACCESS cycle.
REQ-030 PRDATA SHALL be ignored on writes.

Reset
REQ-031 While PRESET=1 at an edge, the block SHALL set:
- state to IDLE, with BUSY=0;
- PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
- ACK=0, ACK_RDATA=0, ACK_ERR=0;
- wait counter to 0 and last granted index to 3.
REQ-032 Reset in SETUP or ACCESS SHALL abandon the transfer with no ACK issued, either during reset or afterwards.

Verification
REQ-033 Single read: REQ=0001, ADDR0=0x0300_0010, PREADY=1, PRDATA=0xA5A5_0001 -> PSEL=0x0008, PENABLE low then high, ACK=0001 on the 3rd edge with ACK_RDATA=0xA5A5_0001 and ACK_ERR=0.
REQ-034 Contention: REQ=1111 held continuously, zero wait states -> grant order 0,1,2,3,0, one ACK every 3 cycles, never two ACK bits high at once.
REQ-035 Wait states with error: write to 0x0F00_0004, PREADY low for 5 cycles then high with PSLVERR=1 -> ACCESS lasts 6 cycles, PSEL=0x8000, ACK_ERR=1, ACK_RDATA=0.
REQ-036 Timeout: TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then ACK with ACK_ERR=1, BUSY=0 and PSEL=0 on the next cycle.
REQ-037 Reset mid-transfer: PRESET=1 for one cycle during ACCESS -> next cycle PSEL=0, PENABLE=0, no ACK; a REQ=0100 then held is granted first and completes normally.
